// File: rtl/uart_pkg.sv
// Shared types and reset constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACC,
    WAIT_DONE
  } sched_state_t;

  localparam logic [3:0] DEF_BAUD  = 4'h0;
  localparam logic       DEF_EIGHT = 1'b1;
  localparam logic       DEF_PEN   = 1'b0;
  localparam logic       DEF_OHEL  = 1'b0;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, modulo N.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int unsigned pos;

  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!valid && req[pos[PW-1:0]]) begin
        valid                = 1'b1;
        winner[pos[PW-1:0]]  = 1'b1;
        idx                  = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit engine between N byte requesters;
// frame configuration is frozen from the load edge until the engine reports idle again.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned ACC_TIMEOUT = 16,
  parameter logic [3:0]  RST_BAUD    = DEF_BAUD
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  input  logic [3:0]     cfg_baud,
  input  logic           cfg_eight,
  input  logic           cfg_pen,
  input  logic           cfg_ohel,
  input  logic           tx_rdy,
  output logic [N-1:0]   grant,
  output logic           load,
  output logic [7:0]     out_data,
  output logic [3:0]     baud_value,
  output logic           EIGHT,
  output logic           PEN,
  output logic           OHEL,
  output logic           busy,
  output logic           frame_done,
  output logic           acc_err
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = (ACC_TIMEOUT > 1) ? $clog2(ACC_TIMEOUT) : 1;

  sched_state_t  state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] acc_cnt_q, acc_cnt_d;
  logic [N-1:0]  grant_d;
  logic          load_d, busy_d, frame_done_d, acc_err_d;
  logic [7:0]    data_d, data_sel;
  logic [3:0]    baud_d;
  logic          eight_d, pen_d, ohel_d;

  logic [N-1:0]  win_oh;
  logic [PW-1:0] win_idx;
  logic          win_vld;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (win_oh),
    .idx    (win_idx),
    .valid  (win_vld)
  );

  always_comb begin
    data_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_idx == PW'(i)) data_sel = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    acc_cnt_d    = acc_cnt_q;
    grant_d      = '0;
    load_d       = 1'b0;
    data_d       = out_data;
    baud_d       = baud_value;
    eight_d      = EIGHT;
    pen_d        = PEN;
    ohel_d       = OHEL;
    frame_done_d = 1'b0;
    acc_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d  = cfg_baud;
        eight_d = cfg_eight;
        pen_d   = cfg_pen;
        ohel_d  = cfg_ohel;
        if (tx_rdy && win_vld) begin
          grant_d   = win_oh;
          load_d    = 1'b1;
          data_d    = data_sel;
          rr_ptr_d  = (win_idx == PW'(N-1)) ? '0 : win_idx + 1'b1;
          acc_cnt_d = '0;
          state_d   = WAIT_ACC;
        end
      end
      WAIT_ACC: begin
        // The edge that would bring acc_cnt to ACC_TIMEOUT-1 is the abort edge.
        if (!tx_rdy) begin
          state_d = WAIT_DONE;
        end else if (acc_cnt_q == AW'(ACC_TIMEOUT-2)) begin
          acc_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          acc_cnt_d = acc_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_rdy) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      acc_cnt_q  <= '0;
      grant      <= '0;
      load       <= 1'b0;
      out_data   <= '0;
      baud_value <= RST_BAUD;
      EIGHT      <= DEF_EIGHT;
      PEN        <= DEF_PEN;
      OHEL       <= DEF_OHEL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      acc_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      acc_cnt_q  <= acc_cnt_d;
      grant      <= grant_d;
      load       <= load_d;
      out_data   <= data_d;
      baud_value <= baud_d;
      EIGHT      <= eight_d;
      PEN        <= pen_d;
      OHEL       <= ohel_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      acc_err    <= acc_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (N=4, ACC_TIMEOUT=16).
module tb_uart_tx_sched;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [3:0]     cfg_baud;
  logic           cfg_eight, cfg_pen, cfg_ohel;
  logic           tx_rdy;
  logic [N-1:0]   grant;
  logic           load;
  logic [7:0]     out_data;
  logic [3:0]     baud_value;
  logic           EIGHT, PEN, OHEL;
  logic           busy, frame_done, acc_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .N           (4),
    .ACC_TIMEOUT (16),
    .RST_BAUD    (4'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .cfg_baud   (cfg_baud),
    .cfg_eight  (cfg_eight),
    .cfg_pen    (cfg_pen),
    .cfg_ohel   (cfg_ohel),
    .tx_rdy     (tx_rdy),
    .grant      (grant),
    .load       (load),
    .out_data   (out_data),
    .baud_value (baud_value),
    .EIGHT      (EIGHT),
    .PEN        (PEN),
    .OHEL       (OHEL),
    .busy       (busy),
    .frame_done (frame_done),
    .acc_err    (acc_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [3:0] b, input logic e, input logic p, input logic o);
    cfg_baud  = b;
    cfg_eight = e;
    cfg_pen   = p;
    cfg_ohel  = o;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tx_rdy = 1'b1;
    req = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Tick until load is seen; returns the number of ticks taken (0 on timeout).
  task automatic wait_load(output int waited);
    waited = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (load === 1'b1) begin
        waited = i;
        break;
      end
    end
    if (waited == 0) check_val("load_timeout", 0, 1);
  endtask

  // Engine model: tx_rdy drops one cycle after load, stays low `hold` cycles, then rises.
  task automatic do_frame(input int hold);
    int fd = 0;
    tick();
    tx_rdy = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      fd += int'(frame_done);
    end
    tx_rdy = 1'b1;
    tick();
    check_val("frame_done_pulse", frame_done, 1);
    check_val("no_load_with_done", load, 0);
    check_val("no_early_done", fd, 0);
  endtask

  initial begin
    int w;
    int fd_count;
    int t;
    logic [N-1:0] exp_g;

    reset = 1'b1;
    req = '0;
    req_data = '0;
    tx_rdy = 1'b1;

    // Reset values, with non-default cfg inputs that must not leak through reset.
    set_cfg(4'h9, 1'b0, 1'b1, 1'b1);
    do_reset();
    check_val("rst_baud", baud_value, 4'h0);
    check_val("rst_eight", EIGHT, 1);
    check_val("rst_pen", PEN, 0);
    check_val("rst_ohel", OHEL, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_data", out_data, 0);
    set_cfg(4'h0, 1'b1, 1'b0, 1'b0);

    // Idle with no requests for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("idle_load", load, 0);
      check_val("idle_grant", grant, 0);
      check_val("idle_busy", busy, 0);
    end
    check_val("idle_eight", EIGHT, 1);
    check_val("idle_pen", PEN, 0);
    check_val("idle_baud", baud_value, 0);

    // Single request from requester 2, 100-cycle frame.
    req = 4'b0100;
    req_data[23:16] = 8'hA5;
    tick();
    check_val("single_grant", grant, 4'b0100);
    check_val("single_load", load, 1);
    check_val("single_data", out_data, 8'hA5);
    check_val("single_busy", busy, 1);
    req = '0;
    tick();
    check_val("single_load_pulse", load, 0);
    check_val("single_grant_pulse", grant, 0);
    tx_rdy = 1'b0;
    fd_count = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      fd_count += int'(frame_done);
    end
    check_val("single_data_held", out_data, 8'hA5);
    tx_rdy = 1'b1;
    tick();
    fd_count += int'(frame_done);
    check_val("single_done_edge", frame_done, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      fd_count += int'(frame_done);
    end
    check_val("single_done_once", fd_count, 1);
    check_val("single_idle_busy", busy, 0);

    // Fairness: all four requesting for 8 frames.
    do_reset();
    req_data = 32'h13121110;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_load(w);
      exp_g = 4'b0001 << (k % 4);
      check_val($sformatf("rr_grant_%0d", k), grant, exp_g);
      check_val($sformatf("rr_data_%0d", k), out_data, 8'h10 + 8'(k % 4));
      if (k > 0) check_val($sformatf("rr_latency_%0d", k), w, 1);
      do_frame(5);
    end
    req = '0;

    // Config frozen during a frame.
    do_reset();
    set_cfg(4'h3, 1'b1, 1'b1, 1'b1);
    req = 4'b0001;
    req_data[7:0] = 8'h55;
    wait_load(w);
    check_val("cfg_baud_load", baud_value, 4'h3);
    check_val("cfg_pen_load", PEN, 1);
    check_val("cfg_ohel_load", OHEL, 1);
    req = '0;
    tick();
    tx_rdy = 1'b0;
    set_cfg(4'h7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check_val("cfg_baud_frozen", baud_value, 4'h3);
    check_val("cfg_pen_frozen", PEN, 1);
    tx_rdy = 1'b1;
    tick();
    check_val("cfg_done", frame_done, 1);
    check_val("cfg_baud_at_done", baud_value, 4'h3);
    tick();
    check_val("cfg_baud_idle", baud_value, 4'h7);
    check_val("cfg_pen_idle", PEN, 0);
    set_cfg(4'h0, 1'b1, 1'b0, 1'b0);

    // Accept timeout: engine never drops tx_rdy.
    do_reset();
    req = 4'b0010;
    req_data[15:8] = 8'h3C;
    wait_load(w);
    check_val("to_grant", grant, 4'b0010);
    req = '0;
    t = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (acc_err === 1'b1) begin
        t = i;
        break;
      end
    end
    check_val("to_latency", t, 15);
    check_val("to_busy", busy, 0);
    check_val("to_no_regrant", grant, 0);
    tick();
    check_val("to_err_pulse", acc_err, 0);
    req = 4'b1000;
    req_data[31:24] = 8'h77;
    wait_load(w);
    check_val("to_next_grant", grant, 4'b1000);
    check_val("to_next_data", out_data, 8'h77);
    req = '0;
    do_frame(3);

    // Reset during WAIT_DONE.
    do_reset();
    req = 4'b0100;
    wait_load(w);
    req = '0;
    tick();
    tx_rdy = 1'b0;
    tick();
    tick();
    check_val("mid_busy_before", busy, 1);
    set_cfg(4'hF, 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    tx_rdy = 1'b1;
    req = 4'b1010;
    tick();
    check_val("mid_busy", busy, 0);
    check_val("mid_done", frame_done, 0);
    check_val("mid_baud", baud_value, 4'h0);
    check_val("mid_eight", EIGHT, 1);
    check_val("mid_pen", PEN, 0);
    check_val("mid_ohel", OHEL, 0);
    check_val("mid_load", load, 0);
    reset = 1'b0;
    set_cfg(4'h0, 1'b1, 1'b0, 1'b0);
    wait_load(w);
    check_val("mid_next_grant", grant, 4'b0010);
    req = '0;
    do_frame(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
